// File: rtl/bcd_updown_counter_pkg.sv
// rtl/bcd_updown_counter_pkg.sv - Shared BCD constants, types and helpers for the counter slice
//
// Purpose : Common definitions shared by the BCD counter and the downstream
//           7-segment decode/serialize stage, so both agree on digit width
//           and default digit count.
// Contents: BCD_W, BCD_MAX, BCD_MIN, BCD_DIGITS, core_state_e, bcd_sat().

package bcd_updown_counter_pkg;

   localparam int                 BCD_W      = 4;
   localparam logic [BCD_W-1:0]   BCD_MAX    = 4'd9;
   localparam logic [BCD_W-1:0]   BCD_MIN    = 4'd0;
   localparam int                 BCD_DIGITS = 6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_UPD  = 1'b1
   } core_state_e;

   // Clamp a nibble into the legal BCD range; anything above 9 becomes 9.
   function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] nib);
      return (nib > BCD_MAX) ? BCD_MAX : nib;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - Register-free single BCD digit up/down cell
//
// Purpose : Combinational next-value logic for one BCD nibble. Chained to
//           form a multi-digit counter; cin/cout are carry when counting up
//           and borrow when counting down.
// Ports   : digit_i  current nibble
//           up_dn_i  1 = increment, 0 = decrement
//           cin_i    carry/borrow in (1 = this digit steps)
//           digit_o  next nibble
//           cout_o   carry/borrow out to the next digit

module bcd_digit
   import bcd_updown_counter_pkg::*;
(
   input  logic [BCD_W-1:0] digit_i,
   input  logic             up_dn_i,
   input  logic             cin_i,
   output logic [BCD_W-1:0] digit_o,
   output logic             cout_o
);

   always_comb begin
      digit_o = digit_i;
      cout_o  = 1'b0;
      if (cin_i) begin
         if (up_dn_i) begin
            // >= rather than == so an illegal nibble still rolls over cleanly
            if (digit_i >= BCD_MAX) begin
               digit_o = BCD_MIN;
               cout_o  = 1'b1;
            end else begin
               digit_o = digit_i + 4'd1;
            end
         end else begin
            if (digit_i == BCD_MIN) begin
               digit_o = BCD_MAX;
               cout_o  = 1'b1;
            end else begin
               digit_o = digit_i - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - Multi-digit BCD up/down event counter with periodic trigger
//
// Purpose : Synchronizes an asynchronous count strobe, counts its rising
//           edges in packed BCD (up or down), supports saturating parallel
//           load and hold, flags wrap, and issues the periodic one-cycle
//           trigger that starts each decode/serialize cycle downstream.
// Build   : define BCD_COUNTER_DEBOUNCE_EN to insert a DEB_CYCLES-long
//           debouncer between the synchronizer and the edge detector.
// Ports   : clk       system clock
//           reset     asynchronous, active-high reset
//           count_in  asynchronous count strobe (rising edge = one event)
//           up_dn     1 = increment, 0 = decrement
//           hold      1 = discard count events
//           load      1 = load load_val (nibbles saturated to 9)
//           load_val  packed BCD load value, digit 0 in [3:0]
//           cnt_out   registered packed BCD count
//           trigger   one-cycle pulse every TRIG_DIV clocks
//           wrap      one-cycle pulse on wrap past all-9s / all-0s

module bcd_updown_counter
   import bcd_updown_counter_pkg::*;
#(
   parameter int DIGITS     = BCD_DIGITS,
   parameter int TRIG_DIV   = 1024,
   parameter int DEB_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    count_in,
   input  logic                    up_dn,
   input  logic                    hold,
   input  logic                    load,
   input  logic [BCD_W*DIGITS-1:0] load_val,
   output logic [BCD_W*DIGITS-1:0] cnt_out,
   output logic                    trigger,
   output logic                    wrap
);

   localparam int                 CW       = BCD_W * DIGITS;
   localparam int                 DIV_W    = (TRIG_DIV > 1) ? $clog2(TRIG_DIV) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TRIG_DIV - 1);

   // arm_q marks when the synchronizer/edge registers hold genuine samples
   // after reset, so a strobe already high at reset release is not an edge.
`ifdef BCD_COUNTER_DEBOUNCE_EN
   localparam int ARM_LEN = 4;
`else
   localparam int ARM_LEN = 3;
`endif

   generate
      if (TRIG_DIV < DIGITS + 24) begin : g_bad_trig_div
         $error("TRIG_DIV must be at least DIGITS+24");
      end
      if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
         $error("DEB_CYCLES must be at least 1");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Input synchronizer and edge detector
   // ------------------------------------------------------------------
   logic               s1_q;
   logic               s2_q;
   logic               s3_q;
   logic [ARM_LEN-1:0] arm_q;
   logic               level;
   logic               evt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         s3_q  <= 1'b0;
         arm_q <= '0;
      end else begin
         s1_q  <= count_in;
         s2_q  <= s1_q;
         s3_q  <= level;
         arm_q <= {arm_q[ARM_LEN-2:0], 1'b1};
      end
   end

`ifdef BCD_COUNTER_DEBOUNCE_EN
   localparam int               DEB_W    = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic             acc_q;
   logic [DEB_W-1:0] deb_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q     <= 1'b0;
         deb_cnt_q <= '0;
      end else if (!arm_q[ARM_LEN-2]) begin
         // Until the synchronizer holds real data, adopt its level directly
         // so a strobe high at reset release is not later seen as an edge.
         acc_q     <= s2_q;
         deb_cnt_q <= '0;
      end else if (s2_q == acc_q) begin
         deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
         acc_q     <= s2_q;
         deb_cnt_q <= '0;
      end else begin
         deb_cnt_q <= deb_cnt_q + 1'b1;
      end
   end

   assign level = acc_q;
`else
   assign level = s2_q;
`endif

   assign evt = level & ~s3_q & arm_q[ARM_LEN-1];

   // ------------------------------------------------------------------
   // Counter core state machine
   // ------------------------------------------------------------------
   core_state_e state_q;
   core_state_e state_d;
   logic        evt_ok;
   logic        wrap_q;
   logic        wrap_d;

   // load beats hold beats event; a dropped event is not remembered
   assign evt_ok = evt & ~hold & ~load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE: state_d = (load || evt_ok) ? ST_UPD : ST_IDLE;
         // Another request straight after an update is taken immediately.
         ST_UPD:  state_d = (load || evt_ok) ? ST_UPD : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wrap = (state_q == ST_UPD) && wrap_q;
   end

   // ------------------------------------------------------------------
   // BCD datapath
   // ------------------------------------------------------------------
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic [CW-1:0]   step_val;
   logic [CW-1:0]   load_sat;
   logic [DIGITS:0] carry;

   assign carry[0] = 1'b1;

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_digit
         bcd_digit u_digit (
            .digit_i (cnt_q[g*BCD_W +: BCD_W]),
            .up_dn_i (up_dn),
            .cin_i   (carry[g]),
            .digit_o (step_val[g*BCD_W +: BCD_W]),
            .cout_o  (carry[g+1])
         );
      end
   endgenerate

   always_comb begin
      load_sat = '0;
      for (int g = 0; g < DIGITS; g++) begin
         load_sat[g*BCD_W +: BCD_W] = bcd_sat(load_val[g*BCD_W +: BCD_W]);
      end
   end

   // Carry out of the top digit only happens from all-9s (up) or all-0s (down).
   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (load) begin
         cnt_d = load_sat;
      end else if (evt_ok) begin
         cnt_d  = step_val;
         wrap_d = carry[DIGITS];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt_out = cnt_q;

   // ------------------------------------------------------------------
   // Trigger divider
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             trig_q;

   always_comb begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
   end

   // Registered from div_d so the pulse lines up with div_q == TRIG_DIV-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q  <= '0;
         trig_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         trig_q <= (div_d == DIV_LAST);
      end
   end

   assign trigger = trig_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - Directed self-checking bench for bcd_updown_counter

module tb_bcd_updown_counter;

   localparam int DIGITS     = 6;
   localparam int W          = 4 * DIGITS;
   localparam int TRIG_DIV   = 32;
   localparam int DEB_CYCLES = 16;
`ifdef BCD_COUNTER_DEBOUNCE_EN
   localparam int LAT = 2 + DEB_CYCLES;
   localparam int PW  = 20;
   localparam logic [W-1:0] PRE_TRIG = 24'h123455;
`else
   localparam int LAT = 2;
   localparam int PW  = 1;
   localparam logic [W-1:0] PRE_TRIG = 24'h123457;
`endif

   logic         clk      = 1'b0;
   logic         reset    = 1'b1;
   logic         count_in = 1'b0;
   logic         up_dn    = 1'b1;
   logic         hold     = 1'b0;
   logic         load     = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] cnt_out;
   logic         trigger;
   logic         wrap;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;

   bcd_updown_counter #(
      .DIGITS     (DIGITS),
      .TRIG_DIV   (TRIG_DIV),
      .DEB_CYCLES (DEB_CYCLES)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .count_in (count_in),
      .up_dn    (up_dn),
      .hold     (hold),
      .load     (load),
      .load_val (load_val),
      .cnt_out  (cnt_out),
      .trigger  (trigger),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_load(input logic [W-1:0] val);
      load_val = val;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
   endtask

   // One strobe pulse of PW clocks; reports wrap cycles seen and the number
   // of negedges after the first sampling edge's preceding negedge until
   // cnt_out first changes (-1 if it never does).
   task automatic pulse(input logic dir, output int wraps, output int lat);
      logic [W-1:0] start;
      start    = cnt_out;
      wraps    = 0;
      lat      = -1;
      up_dn    = dir;
      count_in = 1'b1;
      for (int i = 1; i <= PW + LAT + 8; i++) begin
         @(negedge clk);
         if (wrap) wraps++;
         if (lat < 0 && cnt_out !== start) lat = i;
         if (i == PW) count_in = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr;
      int lt;
      int guard;

      repeat (3) @(negedge clk);
      check("reset_cnt",  32'(cnt_out), 32'h0);
      check("reset_trig", 32'(trigger), 32'h0);
      check("reset_wrap", 32'(wrap),    32'h0);

      // Trigger cadence: pulses in cycles 31, 63, 95 after release.
      reset = 1'b0;
      check("trig_c0", 32'(trigger), 32'h0);
      for (int c = 1; c <= 96; c++) begin
         @(negedge clk);
         check($sformatf("trig_c%0d", c), 32'(trigger), 32'((c % TRIG_DIV) == TRIG_DIV - 1));
      end

      pulse(1'b1, wr, lt);
      check("first_up_val",  32'(cnt_out), 32'h000001);
      check("first_up_lat",  32'(lt),      32'(LAT + 1));
      check("first_up_wrap", 32'(wr),      32'h0);

      do_load(24'h999999);
      check("load_999999", 32'(cnt_out), 32'h999999);
      pulse(1'b1, wr, lt);
      check("up_wrap_val", 32'(cnt_out), 32'h000000);
      check("up_wrap_cnt", 32'(wr),      32'h1);

      do_load(24'h000000);
      pulse(1'b0, wr, lt);
      check("dn_wrap_val", 32'(cnt_out), 32'h999999);
      check("dn_wrap_cnt", 32'(wr),      32'h1);

      do_load(24'h001000);
      pulse(1'b0, wr, lt);
      check("dn_borrow_val",  32'(cnt_out), 32'h000999);
      check("dn_borrow_wrap", 32'(wr),      32'h0);

      do_load(24'h0A0F03);
      check("load_sat", 32'(cnt_out), 32'h090903);

      // Load asserted exactly in the event cycle: load wins, event dropped.
      up_dn    = 1'b1;
      count_in = 1'b1;
      for (int i = 1; i <= LAT; i++) begin
         @(negedge clk);
         if (i == PW) count_in = 1'b0;
      end
      do_load(24'h123456);
      count_in = 1'b0;
      repeat (LAT + 8) @(negedge clk);
      check("load_vs_event", 32'(cnt_out), 32'h123456);

      hold = 1'b1;
      for (int n = 0; n < 5; n++) pulse(1'b1, wr, lt);
      hold = 1'b0;
      check("hold_5_events", 32'(cnt_out), 32'h123456);

      pulse(1'b0, wr, lt);
      check("dn_after_hold", 32'(cnt_out), 32'h123455);

`ifdef BCD_COUNTER_DEBOUNCE_EN
      // 10-clock glitch is shorter than DEB_CYCLES and must not count.
      count_in = 1'b1;
      repeat (10) @(negedge clk);
      count_in = 1'b0;
      repeat (40) @(negedge clk);
      check("glitch_10", 32'(cnt_out), 32'h123455);
`else
      // Two rising edges three clocks apart must both count.
      up_dn    = 1'b1;
      count_in = 1'b1;
      @(negedge clk);
      count_in = 1'b0;
      repeat (2) @(negedge clk);
      count_in = 1'b1;
      @(negedge clk);
      count_in = 1'b0;
      repeat (6) @(negedge clk);
      check("back_to_back", 32'(cnt_out), 32'h123457);
`endif

      // Event landing in a trigger cycle: old value shown in that cycle.
      guard = 0;
      while ((cyc % TRIG_DIV) != (TRIG_DIV - 1 - LAT) && guard < 3 * TRIG_DIV) begin
         @(negedge clk);
         guard++;
      end
      check("trig_align", 32'(guard < 3 * TRIG_DIV), 32'h1);
      up_dn    = 1'b1;
      count_in = 1'b1;
      for (int i = 1; i <= LAT + 1; i++) begin
         @(negedge clk);
         if (i == PW) count_in = 1'b0;
         if (i == LAT) begin
            check("trig_cycle_trig", 32'(trigger), 32'h1);
            check("trig_cycle_old",  32'(cnt_out), 32'(PRE_TRIG));
         end
      end
      count_in = 1'b0;
      check("trig_cycle_new", 32'(cnt_out), 32'(PRE_TRIG + 24'h1));
      repeat (LAT + 8) @(negedge clk);

      // Reset with the strobe held high: cleared, and no event on release.
      count_in = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_cnt", 32'(cnt_out), 32'h0);
      reset = 1'b0;
      repeat (LAT + 10) @(negedge clk);
      check("midreset_no_evt", 32'(cnt_out), 32'h0);
      count_in = 1'b0;
      repeat (LAT + 10) @(negedge clk);
      check("midreset_fall", 32'(cnt_out), 32'h0);
      check("midreset_wrap", 32'(wrap),    32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
